// File: rtl/sram_arb_nx1_if.sv
// sram_arb_nx1_if: sram-like data port bundle, W ports wide.
//   req/wr/size/addr/wdata flow from the requester (master) to the responder (slave);
//   rdata/addr_ok/data_ok flow back. Port i occupies bit i, size bits [2i+1:2i] and
//   addr/wdata/rdata bits [32i+31:32i].
interface sram_arb_nx1_if #(
  parameter int unsigned W = 1
);
  logic [W-1:0]    req;
  logic [W-1:0]    wr;
  logic [2*W-1:0]  size;
  logic [32*W-1:0] addr;
  logic [32*W-1:0] wdata;
  logic [32*W-1:0] rdata;
  logic [W-1:0]    addr_ok;
  logic [W-1:0]    data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_arb_nx1.sv
// sram_arb_nx1: N-to-1 arbiter for sram-like data ports.
//   Grants one master at a time onto the slave port, holds the grant until the address
//   handshake completes, and records the owner of every accepted transaction in an
//   in-order ID FIFO so each data_ok/rdata is routed back to the right master.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   m_bus        N master ports (arbiter acts as their slave)
//   s_bus        single slave-side port (arbiter acts as its master)
//   outstanding  number of IDs currently held in the FIFO
//   err          sticky: s_data_ok arrived while no transaction was outstanding
module sram_arb_nx1 #(
  parameter int unsigned N      = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ARB_RR = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  sram_arb_nx1_if.slave                  m_bus,
  sram_arb_nx1_if.master                 s_bus,
  output logic [$clog2(DEPTH+1)-1:0]     outstanding,
  output logic                           err
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] fifo_q [DEPTH];
  logic [IdxW-1:0] fifo_d [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [N-1:0]    req_v;
  logic [IdxW-1:0] win, win_hi, win_lo, sel, head;
  logic            hi_found, lo_found;
  logic            full, empty, s_req_c, push, pop;

  logic            s_wr_c;
  logic [1:0]      s_size_c;
  logic [31:0]     s_addr_c, s_wdata_c;
  logic [N-1:0]    m_addr_ok_c, m_data_ok_c;
  logic [32*N-1:0] m_rdata_c;

  // Masking requests in reset keeps every output at zero while resetn is low.
  assign req_v = resetn ? m_bus.req : '0;
  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];
  assign pop   = resetn & s_bus.data_ok[0] & ~empty;

  // Winner selection. win_lo is the lowest requester overall; win_hi is the lowest
  // requester at or above rr_ptr. Preferring win_hi gives the wrap-around search.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_v[i]) begin
        win_lo   = IdxW'(i);
        lo_found = 1'b1;
        if ((ARB_RR != 0) && (IdxW'(i) >= rr_ptr_q)) begin
          win_hi   = IdxW'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? win_hi : win_lo;
  end

  // Grant FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel     = win;
    s_req_c = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Full is judged on the registered count, so a same-cycle pop does not help.
        if (!full && lo_found) begin
          s_req_c = 1'b1;
          if (s_bus.addr_ok[0]) begin
            push = 1'b1;
          end else begin
            gnt_d   = win;
            state_d = StLock;
          end
        end
      end
      StLock: begin
        sel     = gnt_q;
        s_req_c = req_v[gnt_q];
        if (!req_v[gnt_q]) begin
          // Master withdrew before acceptance: abandon the grant.
          state_d = StIdle;
        end else if (s_bus.addr_ok[0]) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slave-side request mux; fields are zero whenever no request is presented.
  always_comb begin
    s_wr_c    = 1'b0;
    s_size_c  = '0;
    s_addr_c  = '0;
    s_wdata_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (s_req_c && (sel == IdxW'(i))) begin
        s_wr_c    = m_bus.wr[i];
        s_size_c  = m_bus.size[2*i +: 2];
        s_addr_c  = m_bus.addr[32*i +: 32];
        s_wdata_c = m_bus.wdata[32*i +: 32];
      end
    end
  end

  // Per-master handshake and return-path decode.
  always_comb begin
    m_addr_ok_c = '0;
    m_data_ok_c = '0;
    m_rdata_c   = '0;
    for (int i = 0; i < int'(N); i++) begin
      m_addr_ok_c[i] = push && (sel == IdxW'(i));
      m_data_ok_c[i] = pop && (head == IdxW'(i));
      if (m_data_ok_c[i]) begin
        m_rdata_c[32*i +: 32] = s_bus.rdata;
      end
    end
  end

  // ID FIFO, round-robin pointer and error flag.
  always_comb begin
    fifo_d   = fifo_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    // Covers data_ok alongside a brand-new push: the new ID is not yet in the FIFO.
    err_d    = err_q | (s_bus.data_ok[0] & empty);
    if (push) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = wptr_q + PtrW'(1);
      rr_ptr_d       = (sel == IdxW'(N - 1)) ? '0 : sel + IdxW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
    end
  end

  assign s_bus.req     = s_req_c;
  assign s_bus.wr      = s_wr_c;
  assign s_bus.size    = s_size_c;
  assign s_bus.addr    = s_addr_c;
  assign s_bus.wdata   = s_wdata_c;
  assign m_bus.addr_ok = m_addr_ok_c;
  assign m_bus.data_ok = m_data_ok_c;
  assign m_bus.rdata   = m_rdata_c;
  assign outstanding   = cnt_q;
  assign err           = err_q;

endmodule

// File: tb/tb_sram_arb_nx1.sv
// Randomized bench for sram_arb_nx1 (N=3, DEPTH=2, round-robin) against a queue-based
// reference model of the arbitration, lock and in-order return rules.
module tb_sram_arb_nx1;
  localparam int unsigned N      = 3;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned ARB_RR = 1;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [CntW-1:0] outstanding;
  logic            err;

  sram_arb_nx1_if #(.W(N)) m_bus ();
  sram_arb_nx1_if #(.W(1)) s_bus ();

  sram_arb_nx1 #(.N(N), .DEPTH(DEPTH), .ARB_RR(ARB_RR)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m_bus       (m_bus.slave),
    .s_bus       (s_bus.master),
    .outstanding (outstanding),
    .err         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int   ids[$];
  int   rr;
  bit   locked;
  int   lock_g;
  bit   merr;

  // Per-master pending request and its fields.
  bit          pend [N];
  logic        f_wr [N];
  logic [1:0]  f_size [N];
  logic [31:0] f_addr [N];
  logic [31:0] f_wdata [N];

  logic [N-1:0] mreq;
  int           g, c;
  bit           sreq, hs, pop;
  logic [127:0] e_aok, e_dok, e_rdata;

  initial begin
    rr = 0; locked = 0; lock_g = 0; merr = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; f_wr[i] = 0; f_size[i] = 0; f_addr[i] = 0; f_wdata[i] = 0;
    end
    m_bus.req = '0; m_bus.wr = '0; m_bus.size = '0; m_bus.addr = '0; m_bus.wdata = '0;
    s_bus.rdata = '0; s_bus.addr_ok = '0; s_bus.data_ok = '0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      resetn = !((cyc < 2) || ($urandom_range(0, 299) == 0));
      for (int i = 0; i < N; i++) begin
        m_bus.req[i]            = pend[i];
        m_bus.wr[i]             = f_wr[i];
        m_bus.size[2*i +: 2]    = f_size[i];
        m_bus.addr[32*i +: 32]  = f_addr[i];
        m_bus.wdata[32*i +: 32] = f_wdata[i];
        mreq[i]                 = pend[i];
      end
      s_bus.addr_ok = 1'($urandom_range(0, 1));
      s_bus.data_ok = 1'($urandom_range(0, 2) == 0);
      s_bus.rdata   = $urandom;
      #1;

      // Expected outputs for this cycle.
      sreq = 0;
      g    = 0;
      if (resetn) begin
        if (locked) begin
          g    = lock_g;
          sreq = mreq[g];
        end else if (ids.size() < DEPTH && mreq != '0) begin
          sreq = 1;
          g    = -1;
          for (int k = 0; k < N; k++) begin
            c = (rr + k) % N;
            if (g < 0 && mreq[c]) g = c;
          end
        end
      end
      hs      = sreq && s_bus.addr_ok[0];
      pop     = resetn && s_bus.data_ok[0] && ids.size() > 0;
      e_aok   = hs ? (128'd1 << g) : '0;
      e_dok   = pop ? (128'd1 << ids[0]) : '0;
      e_rdata = pop ? ({96'd0, s_bus.rdata} << (32 * ids[0])) : '0;

      check_eq("s_req", s_bus.req, sreq);
      check_eq("s_addr", s_bus.addr, sreq ? f_addr[g] : 32'd0);
      check_eq("s_wr", s_bus.wr, sreq ? f_wr[g] : 1'b0);
      check_eq("s_size", s_bus.size, sreq ? f_size[g] : 2'd0);
      check_eq("s_wdata", s_bus.wdata, sreq ? f_wdata[g] : 32'd0);
      check_eq("m_addr_ok", m_bus.addr_ok, e_aok);
      check_eq("m_data_ok", m_bus.data_ok, e_dok);
      check_eq("m_rdata", m_bus.rdata, e_rdata);
      check_eq("outstanding", outstanding, resetn ? ids.size() : 0);
      check_eq("err", err, resetn ? merr : 1'b0);

      // Advance the model across the coming clock edge.
      if (!resetn) begin
        ids.delete();
        rr = 0; locked = 0; merr = 0;
      end else begin
        if (s_bus.data_ok[0] && ids.size() == 0) merr = 1;
        if (pop) void'(ids.pop_front());
        if (hs) begin
          ids.push_back(g);
          rr     = (g + 1) % N;
          locked = 0;
          pend[g] = 0;
        end else if (sreq && !locked) begin
          locked = 1;
          lock_g = g;
        end else if (locked && !mreq[lock_g]) begin
          locked = 0;
        end
      end

      // New master activity; occasional withdrawal exercises the abandoned-grant path.
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 39) == 0) pend[i] = 0;
        end else if ($urandom_range(0, 1) == 1) begin
          pend[i]    = 1;
          f_wr[i]    = 1'($urandom_range(0, 1));
          f_size[i]  = 2'($urandom_range(0, 3));
          f_addr[i]  = $urandom;
          f_wdata[i] = $urandom;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
